hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Stall/flush controller for the LC-3b 5-stage pipeline: drives the `stall` inputs of the IF, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers and their flush/bubble controls.
- Sources: memory wait states, load-use hazards and taken control transfers resolved in MEM.
- Tracks stale instruction fetches after a redirect and flags memory hangs via a watchdog.

Parameters:
- REG_IDX_W, 3, register index width.
- MEM_TIMEOUT, 1024, consecutive memory-wait cycles before `mem_timeout` sets.
- CNT_W, 16, watchdog and performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_sr1, id_sr2  in  REG_IDX_W  ID source register indices.
- id_sr1_used, id_sr2_used  in  1  the matching source is actually read.
- exe_valid, exe_is_load, exe_writes_reg  in  1  EXE instruction qualifiers.
- exe_dest  in  REG_IDX_W  EXE destination register.
- imem_read, imem_resp  in  1  I-cache request / response.
- dmem_req, dmem_resp  in  1  D-cache request (MEM stage) / response.
- br_taken_mem  in  1  taken branch/JMP/JSR/TRAP resolved in MEM.
- stall_if, stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb  out  1  1 = register holds its value.
- flush_if_id, flush_exe_mem  out  1  register loads a NOP packet.
- bubble_id_exe  out  1  ID/EXE loads a NOP packet; also used as the branch flush.
- mem_timeout  out  1  sticky watchdog error.

Behaviour:
- Derived terms:
  - dmem_wait = dmem_req & ~dmem_resp.
  - imem_wait = imem_read & ~imem_resp.
  - load_use = exe_valid & exe_is_load & exe_writes_reg & id_valid & ((id_sr1_used & id_sr1==exe_dest) | (id_sr2_used & id_sr2==exe_dest)).
- Control outputs are combinational from the inputs and state; zero latency.
- Any output not named in a case below is 0.
- While reset is high, every control output is 0; state=RUN, watchdog count=0, mem_timeout=0.
- States: RUN, DISCARD.
- RUN, highest priority first:
  1. dmem_wait: all five stall_* = 1; no flush or bubble. A coincident br_taken_mem is ignored this cycle and is seen again later because EXE/MEM holds.
  2. br_taken_mem: flush_if_id = 1, bubble_id_exe = 1, flush_exe_mem = 1; all stalls 0, so the PC loads the target.
     - If imem_wait is also 1 this cycle: next state = DISCARD. The I-cache keeps the old address latched for the outstanding request.
  3. load_use: stall_if = 1, stall_if_id = 1, bubble_id_exe = 1.
     - Lasts exactly one cycle, since the load then moves to MEM.
     - Also covers a coincident imem_wait.
  4. imem_wait: stall_if = 1, flush_if_id = 1, so NOPs flow downstream.
  5. Otherwise all outputs 0.
- DISCARD:
  - stall_if = 1 (PC holds the target) and flush_if_id = 1 every cycle, including the imem_resp cycle, so the stale fetch is dropped.
  - Leave for RUN on the cycle after imem_resp is 1.
  - dmem_wait has priority: all stalls 1 and flush_if_id still 1.
  - br_taken_mem in DISCARD cannot occur: the pipeline holds only NOPs behind the redirect.
- Watchdog:
  - The count increments on any cycle with dmem_wait | imem_wait and clears to 0 on any other cycle.
  - When the count reaches MEM_TIMEOUT, mem_timeout sets and stays 1 until reset.
  - The count saturates.
- Reset asserted mid-stall or in DISCARD: state returns to RUN immediately, asynchronously.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds three CNT_W-bit outputs, each a saturating counter cleared by reset:
  - perf_stall_cycles: cycles with stall_mem_wb = 1.
  - perf_bubbles: cycles with load_use-driven bubble_id_exe.
  - perf_flushes: cycles where a br_taken_mem redirect is taken, excluding cycles where dmem_wait suppresses it.
- When undefined, the outputs and counters do not exist; all other behaviour is identical.

Test Plan:
- Load-use: exe load R3, ID uses sr1 = R3 -> for 1 cycle stall_if = 1, stall_if_id = 1, bubble_id_exe = 1; next cycle all 0. Repeat with sr1_used = 0 -> no stall.
- D-cache wait: dmem_req = 1 and dmem_resp low for 4 cycles -> all stalls 1 for 4 cycles; the resp cycle -> all 0.
- Branch vs memory: br_taken_mem = 1 with dmem_wait = 1 -> stalls only and no flush. Then dmem_resp = 1 -> on the next cycle, flush_if_id, bubble_id_exe and flush_exe_mem = 1.
- Stale fetch:
  - Stimulus: br_taken_mem = 1 with imem_read = 1 and imem_resp = 0, then imem_resp = 1 after 3 cycles.
  - Response: DISCARD for 3 cycles plus the resp cycle, with stall_if = 1 and flush_if_id = 1; RUN afterwards, with stall_if = 0 on an idle I-cache.
- Watchdog: MEM_TIMEOUT = 8, imem_resp held low -> mem_timeout rises after 8 wait cycles and stays 1 after resp; reset clears it asynchronously.
- Reset mid-DISCARD: assert reset between clock edges -> outputs 0 immediately; after release, state is RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the LC-3b 5-stage pipeline, with stale-fetch discard and memory watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int unsigned REG_IDX_W   = 3,
    parameter int unsigned MEM_TIMEOUT = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_sr1,
    input  logic [REG_IDX_W-1:0] id_sr2,
    input  logic                 id_sr1_used,
    input  logic                 id_sr2_used,
    input  logic                 exe_valid,
    input  logic                 exe_is_load,
    input  logic                 exe_writes_reg,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 imem_read,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic                 br_taken_mem,
    output logic                 stall_if,
    output logic                 stall_if_id,
    output logic                 stall_id_exe,
    output logic                 stall_exe_mem,
    output logic                 stall_mem_wb,
    output logic                 flush_if_id,
    output logic                 flush_exe_mem,
    output logic                 bubble_id_exe,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0]     perf_stall_cycles,
    output logic [CNT_W-1:0]     perf_bubbles,
    output logic [CNT_W-1:0]     perf_flushes,
`endif
    output logic                 mem_timeout
);

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic              timeout_q, timeout_d;

    logic dmem_wait, imem_wait, load_use;
    logic lu_bubble, br_redirect;

    assign dmem_wait = dmem_req & ~dmem_resp;
    assign imem_wait = imem_read & ~imem_resp;
    assign load_use  = exe_valid & exe_is_load & exe_writes_reg & id_valid &
                       ((id_sr1_used & (id_sr1 == exe_dest)) |
                        (id_sr2_used & (id_sr2 == exe_dest)));

    always_comb begin
        state_d       = state_q;
        stall_if      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_exe  = 1'b0;
        stall_exe_mem = 1'b0;
        stall_mem_wb  = 1'b0;
        flush_if_id   = 1'b0;
        flush_exe_mem = 1'b0;
        bubble_id_exe = 1'b0;
        lu_bubble     = 1'b0;
        br_redirect   = 1'b0;
        if (!reset) begin
            unique case (state_q)
                RUN: begin
                    if (dmem_wait) begin
                        stall_if      = 1'b1;
                        stall_if_id   = 1'b1;
                        stall_id_exe  = 1'b1;
                        stall_exe_mem = 1'b1;
                        stall_mem_wb  = 1'b1;
                    end else if (br_taken_mem) begin
                        br_redirect   = 1'b1;
                        flush_if_id   = 1'b1;
                        bubble_id_exe = 1'b1;
                        flush_exe_mem = 1'b1;
                        // Outstanding fetch is for the old path; drop it when it returns
                        if (imem_wait) state_d = DISCARD;
                    end else if (load_use) begin
                        lu_bubble     = 1'b1;
                        stall_if      = 1'b1;
                        stall_if_id   = 1'b1;
                        bubble_id_exe = 1'b1;
                    end else if (imem_wait) begin
                        stall_if      = 1'b1;
                        flush_if_id   = 1'b1;
                    end
                end
                DISCARD: begin
                    stall_if    = 1'b1;
                    flush_if_id = 1'b1;
                    if (dmem_wait) begin
                        stall_if_id   = 1'b1;
                        stall_id_exe  = 1'b1;
                        stall_exe_mem = 1'b1;
                        stall_mem_wb  = 1'b1;
                    end
                    if (imem_resp) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        wd_cnt_d = '0;
        if (dmem_wait | imem_wait)
            wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 1'b1;
        timeout_d = timeout_q | (32'(wd_cnt_d) >= MEM_TIMEOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_bub_q, perf_bub_d;
    logic [CNT_W-1:0] perf_fl_q, perf_fl_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_bub_d   = perf_bub_q;
        perf_fl_d    = perf_fl_q;
        if (stall_mem_wb && perf_stall_q != '1) perf_stall_d = perf_stall_q + 1'b1;
        if (lu_bubble    && perf_bub_q   != '1) perf_bub_d   = perf_bub_q + 1'b1;
        if (br_redirect  && perf_fl_q    != '1) perf_fl_d    = perf_fl_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_bub_q   <= '0;
            perf_fl_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_bub_q   <= perf_bub_d;
            perf_fl_q    <= perf_fl_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_bubbles      = perf_bub_q;
    assign perf_flushes      = perf_fl_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT overridden to 8).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_sr1_used, id_sr2_used;
    logic [2:0] id_sr1, id_sr2, exe_dest;
    logic       exe_valid, exe_is_load, exe_writes_reg;
    logic       imem_read, imem_resp, dmem_req, dmem_resp, br_taken_mem;
    logic       stall_if, stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb;
    logic       flush_if_id, flush_exe_mem, bubble_id_exe, mem_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // {stall_if, stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb, flush_if_id, bubble_id_exe, flush_exe_mem}
    localparam logic [7:0] C_IDLE  = 8'b00000_0_0_0;
    localparam logic [7:0] C_DSTL  = 8'b11111_0_0_0;
    localparam logic [7:0] C_BR    = 8'b00000_1_1_1;
    localparam logic [7:0] C_LU    = 8'b11000_0_1_0;
    localparam logic [7:0] C_IW    = 8'b10000_1_0_0;
    localparam logic [7:0] C_DISCD = 8'b11111_1_0_0;

    hazard_ctrl #(.REG_IDX_W(3), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_sr1(id_sr1), .id_sr2(id_sr2),
        .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
        .exe_valid(exe_valid), .exe_is_load(exe_is_load), .exe_writes_reg(exe_writes_reg),
        .exe_dest(exe_dest),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .br_taken_mem(br_taken_mem),
        .stall_if(stall_if), .stall_if_id(stall_if_id), .stall_id_exe(stall_id_exe),
        .stall_exe_mem(stall_exe_mem), .stall_mem_wb(stall_mem_wb),
        .flush_if_id(flush_if_id), .flush_exe_mem(flush_exe_mem),
        .bubble_id_exe(bubble_id_exe), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    wire [7:0] ctl = {stall_if, stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb,
                      flush_if_id, bubble_id_exe, flush_exe_mem};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_sr1 = 0; id_sr2 = 0; id_sr1_used = 0; id_sr2_used = 0;
        exe_valid = 0; exe_is_load = 0; exe_writes_reg = 0; exe_dest = 0;
        imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0; br_taken_mem = 0;
    endtask

    task automatic set_load_r3();
        exe_valid = 1; exe_is_load = 1; exe_writes_reg = 1; exe_dest = 3'd3;
        id_valid = 1;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        dmem_req = 1; br_taken_mem = 1; imem_read = 1;
        #1;
        check_eq("reset_ctl", 32'(ctl), 32'(C_IDLE));
        check_eq("reset_timeout", 32'(mem_timeout), 0);
        tick(); tick();
        idle_inputs();
        #2 reset = 0;
        #1 check_eq("idle_after_reset", 32'(ctl), 32'(C_IDLE));

        // Load-use on sr1 for one cycle, then load has left EXE
        tick(); set_load_r3(); id_sr1 = 3'd3; id_sr1_used = 1; #1;
        check_eq("lu_sr1", 32'(ctl), 32'(C_LU));
        tick(); exe_valid = 0; exe_is_load = 0; exe_writes_reg = 0; #1;
        check_eq("lu_released", 32'(ctl), 32'(C_IDLE));
        tick(); set_load_r3(); id_sr1 = 3'd3; id_sr1_used = 0; #1;
        check_eq("lu_sr1_unused", 32'(ctl), 32'(C_IDLE));
        id_sr2 = 3'd3; id_sr2_used = 1; #1;
        check_eq("lu_sr2", 32'(ctl), 32'(C_LU));
        exe_writes_reg = 0; #1;
        check_eq("lu_nowrite", 32'(ctl), 32'(C_IDLE));
        exe_writes_reg = 1; id_sr2 = 3'd4; #1;
        check_eq("lu_other_reg", 32'(ctl), 32'(C_IDLE));
        id_sr2 = 3'd3; imem_read = 1; #1;
        check_eq("lu_over_imem", 32'(ctl), 32'(C_LU));
        imem_read = 0; br_taken_mem = 1; #1;
        check_eq("br_over_lu", 32'(ctl), 32'(C_BR));
        tick(); idle_inputs(); #1;
        check_eq("run_after_br", 32'(ctl), 32'(C_IDLE));

        // D-cache wait for 4 cycles, then response
        for (int i = 0; i < 4; i++) begin
            tick(); dmem_req = 1; dmem_resp = 0; #1;
            check_eq($sformatf("dwait_%0d", i), 32'(ctl), 32'(C_DSTL));
        end
        tick(); dmem_resp = 1; #1;
        check_eq("dwait_resp", 32'(ctl), 32'(C_IDLE));

        // Branch held off by D-cache wait, then taken when the response arrives
        tick(); br_taken_mem = 1; dmem_req = 1; dmem_resp = 0; #1;
        check_eq("br_under_dwait", 32'(ctl), 32'(C_DSTL));
        tick(); dmem_resp = 1; #1;
        check_eq("br_after_dwait", 32'(ctl), 32'(C_BR));
        tick(); idle_inputs(); #1;
        check_eq("br_done", 32'(ctl), 32'(C_IDLE));

        tick(); imem_read = 1; #1;
        check_eq("imem_wait", 32'(ctl), 32'(C_IW));
        imem_resp = 1; #1;
        check_eq("imem_resp_run", 32'(ctl), 32'(C_IDLE));

        // Stale fetch: redirect with an outstanding I-cache miss
        tick(); idle_inputs(); br_taken_mem = 1; imem_read = 1; #1;
        check_eq("stale_br", 32'(ctl), 32'(C_BR));
        for (int i = 0; i < 3; i++) begin
            tick(); br_taken_mem = 0; imem_read = 1; imem_resp = 0;
            dmem_req = (i == 1); #1;
            check_eq($sformatf("discard_%0d", i), 32'(ctl), 32'(i == 1 ? C_DISCD : C_IW));
        end
        tick(); dmem_req = 0; imem_resp = 1; #1;
        check_eq("discard_resp", 32'(ctl), 32'(C_IW));
        tick(); idle_inputs(); #1;
        check_eq("run_after_discard", 32'(ctl), 32'(C_IDLE));

        // Watchdog: 8 consecutive I-cache wait cycles
        for (int i = 0; i < 8; i++) begin
            tick(); imem_read = 1; imem_resp = 0; #1;
            check_eq($sformatf("wd_pending_%0d", i), 32'(mem_timeout), 0);
        end
        tick(); #1;
        check_eq("wd_set", 32'(mem_timeout), 1);
        imem_resp = 1;
        tick(); idle_inputs(); #1;
        check_eq("wd_sticky", 32'(mem_timeout), 1);

        // Asynchronous reset while in DISCARD
        tick(); br_taken_mem = 1; imem_read = 1; #1;
        tick(); br_taken_mem = 0; #1;
        check_eq("pre_reset_discard", 32'(ctl), 32'(C_IW));
        #2 reset = 1; #1;
        check_eq("async_reset_ctl", 32'(ctl), 32'(C_IDLE));
        check_eq("async_reset_timeout", 32'(mem_timeout), 0);
        idle_inputs();
        #1 reset = 0;
        tick(); #1;
        check_eq("run_after_reset", 32'(ctl), 32'(C_IDLE));
        check_eq("timeout_after_reset", 32'(mem_timeout), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
